// File: rtl/pcd8544_pkg.sv
// Shared state encoding and PCD8544 panel geometry for the refresh sequencer.
package pcd8544_pkg;

  localparam int LCD_COLS        = 84;
  localparam int LCD_ROWS        = 48;
  localparam int LCD_FRAME_BYTES = LCD_COLS * LCD_ROWS / 8;
  localparam int PCD_CFG_BYTES   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LCD_RST,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pcd8544_refresh_ctrl_if.sv
// Control, frame-RAM and LCD pin bundle of the refresh sequencer.
// The sequencer uses master; the RAM/pin side uses slave.
interface pcd8544_refresh_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              lcd_rst_n;
  logic              lcd_ce_n;
  logic              lcd_dc;
  logic              lcd_sck;
  logic              lcd_mosi;

  modport master (
    input  start, mem_data,
    output busy, done, mem_addr, lcd_rst_n, lcd_ce_n, lcd_dc, lcd_sck, lcd_mosi
  );

  modport slave (
    output start, mem_data,
    input  busy, done, mem_addr, lcd_rst_n, lcd_ce_n, lcd_dc, lcd_sck, lcd_mosi
  );
endinterface

// File: rtl/pcd8544_refresh_ctrl_spi_byte_tx.sv
// SPI mode-0 byte serializer, MSB first: 16*CLK_DIV clk per byte after load_i.
// No backpressure; last_o flags the final high-phase cycle so the caller can chain bytes.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       clear_i,
  input  logic [7:0] data_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       busy_o,
  output logic       last_o
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_q, bit_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             act_q, act_d;
  logic             phase_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      sr_q   <= '0;
      bit_q  <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      sr_q   <= sr_d;
      bit_q  <= bit_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      act_q  <= act_d;
    end
  end

  always_comb begin
    div_d  = div_q;
    sr_d   = sr_q;
    bit_d  = bit_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    act_d  = act_q;
    phase_end = act_q && (div_q == DIV_W'(CLK_DIV - 1));
    last_o    = phase_end && sck_q && (bit_q == 3'd7);
    if (load_i) begin
      sr_d   = data_i;
      mosi_d = data_i[7];
      sck_d  = 1'b0;
      div_d  = '0;
      bit_d  = '0;
      act_d  = 1'b1;
    end else if (clear_i) begin
      mosi_d = 1'b0;
      sck_d  = 1'b0;
      div_d  = '0;
      bit_d  = '0;
      act_d  = 1'b0;
    end else if (act_q) begin
      if (phase_end) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          // Falling edge: advance to the next bit while sck is low.
          sck_d  = 1'b0;
          sr_d   = {sr_q[6:0], 1'b0};
          mosi_d = sr_q[6];
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) act_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign busy_o = act_q;
endmodule

// File: rtl/pcd8544_refresh_ctrl.sv
// PCD8544 refresh: LCD reset pulse, then CFG+DATA bytes from frame RAM over SPI, 3+16*CLK_DIV clk/byte.
// No backpressure; start is ignored while busy. PCD8544_CONT_REFRESH_EN loops data bytes forever.
module pcd8544_refresh_ctrl
  import pcd8544_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int CFG_BYTES  = PCD_CFG_BYTES,
  parameter int DATA_BYTES = LCD_FRAME_BYTES,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst,
  pcd8544_refresh_ctrl_if.master bus
);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] CFG_END  = ADDR_W'(CFG_BYTES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CFG_BYTES + DATA_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              lcd_rst_n_q, lcd_rst_n_d;
  logic              ce_n_q, ce_n_d;
  logic              dc_q, dc_d;
  logic              tx_load, tx_clear, tx_busy, tx_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      rcnt_q      <= '0;
      lcd_rst_n_q <= 1'b1;
      ce_n_q      <= 1'b1;
      dc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      rcnt_q      <= rcnt_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      ce_n_q      <= ce_n_d;
      dc_q        <= dc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    rcnt_d      = rcnt_q;
    lcd_rst_n_d = lcd_rst_n_q;
    ce_n_d      = ce_n_q;
    dc_d        = dc_q;
    tx_load     = 1'b0;
    tx_clear    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_LCD_RST;
          rcnt_d      = '0;
          lcd_rst_n_d = 1'b0;
        end
      end
      ST_LCD_RST: begin
        if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d     = ST_FETCH;
          idx_d       = '0;
          lcd_rst_n_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_FETCH: begin
        addr_d  = idx_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        if (!tx_busy) begin
          tx_load = 1'b1;
          ce_n_d  = 1'b0;
          dc_d    = (idx_q >= CFG_END);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tx_last) begin
          if (idx_q == LAST_IDX) begin
            // ce_n, dc and mosi settle during the done cycle itself.
            state_d  = ST_DONE;
            ce_n_d   = 1'b1;
            dc_d     = 1'b0;
            tx_clear = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
`ifdef PCD8544_CONT_REFRESH_EN
        state_d = ST_FETCH;
        idx_d   = CFG_END;
        ce_n_d  = 1'b0;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load),
    .clear_i (tx_clear),
    .data_i  (bus.mem_data),
    .sck_o   (bus.lcd_sck),
    .mosi_o  (bus.lcd_mosi),
    .busy_o  (tx_busy),
    .last_o  (tx_last)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.mem_addr  = addr_q;
  assign bus.lcd_rst_n = lcd_rst_n_q;
  assign bus.lcd_ce_n  = ce_n_q;
  assign bus.lcd_dc    = dc_q;
endmodule

// File: tb/tb_pcd8544_refresh_ctrl.sv
// Scoreboard bench for pcd8544_refresh_ctrl: RAM model, SPI decoder and frame timing checks.
module tb_pcd8544_refresh_ctrl;
  import pcd8544_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 16;
  localparam int CFG_N      = PCD_CFG_BYTES;
  localparam int TOTAL      = CFG_N + LCD_FRAME_BYTES;
  localparam int BYTE_CYC   = 3 + 16 * CLK_DIV;
  localparam int FRAME_CYC  = RST_CYCLES + TOTAL * BYTE_CYC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pcd8544_refresh_ctrl_if #(.ADDR_W(13)) bus ();

  pcd8544_refresh_ctrl #(
    .ADDR_W     (13),
    .CFG_BYTES  (CFG_N),
    .DATA_BYTES (LCD_FRAME_BYTES),
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:8191];
  always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries are {dc, byte}.
  logic [8:0] exp_q[$];

  task automatic push_frame();
    for (int i = 0; i < TOTAL; i++)
      exp_q.push_back({(i >= CFG_N) ? 1'b1 : 1'b0, ram[i]});
  endtask

  int         nbit = 0, nbyte = 0, run = 0;
  int         hp_err = 0, dc_err = 0, ce_err = 0, addr_err = 0;
  int         n_done = 0, rst_lo = 0;
  int         byte_t [0:15];
  logic       sck_prev = 1'b0;
  logic       byte_dc = 1'b0;
  logic [7:0] rx = 8'h00;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) begin
      nbit = 0;
      nbyte = 0;
      run = 0;
      sck_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.done) n_done++;
      if (!bus.lcd_rst_n) rst_lo++;
      if (bus.lcd_sck == sck_prev) begin
        run++;
      end else begin
        if ((sck_prev || nbit != 0) && run != CLK_DIV) hp_err++;
        run = 1;
        if (bus.lcd_sck) begin
          if (bus.lcd_ce_n) ce_err++;
          if (nbit == 0) begin
            byte_dc = bus.lcd_dc;
            if (bus.mem_addr != 13'(nbyte)) addr_err++;
          end else if (bus.lcd_dc != byte_dc) begin
            dc_err++;
          end
          rx = {rx[6:0], bus.lcd_mosi};
          nbit++;
          if (nbit == 8) begin
            nbit = 0;
            if (nbyte < 16) byte_t[nbyte] = cyc;
            nbyte++;
            if (exp_q.size() == 0) begin
              chk("sb_unexpected_byte", 32'(nbyte), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("rx_byte", 32'(rx), 32'(e[7:0]));
              chk("rx_dc", 32'(byte_dc), 32'(e[8]));
            end
          end
        end
      end
      sck_prev = bus.lcd_sck;
    end
  end

  task automatic do_start(output int t0);
    @(posedge clk);
    #1 bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  initial begin
    int t0, lo, d0, r0;
    bit hit;
    for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
    bus.start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",     32'(bus.busy),      32'd0);
    chk("rst_done",     32'(bus.done),      32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
    chk("rst_lcd_rst_n",32'(bus.lcd_rst_n), 32'd1);
    chk("rst_ce_n",     32'(bus.lcd_ce_n),  32'd1);
    chk("rst_dc",       32'(bus.lcd_dc),    32'd0);
    chk("rst_sck",      32'(bus.lcd_sck),   32'd0);
    chk("rst_mosi",     32'(bus.lcd_mosi),  32'd0);
    rst = 1'b0;

    lo = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.lcd_ce_n !== 1'b1 || bus.lcd_rst_n !== 1'b1 || bus.busy !== 1'b0) lo++;
    end
    chk("idle_hold", 32'(lo), 32'd0);

    // Frame 1: reset pulse, serialization of 0xA5, then reset inside byte 7.
    ram[0] = 8'hA5;
    push_frame();
    do_start(t0);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    lo = 0;
    for (int i = 0; i < 4 * RST_CYCLES; i++) begin
      @(negedge clk);
      if (!bus.lcd_rst_n) lo++;
      else if (lo > 0) break;
    end
    chk("rst_low_cycles", 32'(lo), 32'(RST_CYCLES));
    @(negedge clk);
    chk("first_addr", 32'(bus.mem_addr), 32'd0);

    hit = 1'b0;
    for (int i = 0; i < 20 * BYTE_CYC && !hit; i++) begin
      @(negedge clk);
      hit = (nbyte == 7 && nbit == 3);
    end
    chk("reach_byte7_bit3", 32'(hit), 32'd1);
    chk("byte_period", 32'(byte_t[1] - byte_t[0]), 32'(BYTE_CYC));

    d0 = n_done;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_sck",     32'(bus.lcd_sck),   32'd0);
    chk("mid_ce_n",    32'(bus.lcd_ce_n),  32'd1);
    chk("mid_busy",    32'(bus.busy),      32'd0);
    chk("mid_done",    32'(bus.done),      32'd0);
    chk("mid_rst_n",   32'(bus.lcd_rst_n), 32'd1);
    chk("mid_dc",      32'(bus.lcd_dc),    32'd0);
    chk("mid_mosi",    32'(bus.lcd_mosi),  32'd0);
    chk("mid_addr",    32'(bus.mem_addr),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no_done_after_rst", 32'(n_done - d0), 32'd0);

    // Frame 2: full frame with the command/data boundary table and a stray start.
    ram[0] = 8'h21; ram[1] = 8'hB1; ram[2] = 8'h04;
    ram[3] = 8'h14; ram[4] = 8'h20; ram[5] = 8'hAA;
    push_frame();
    r0 = rst_lo;
    d0 = n_done;
    do_start(t0);
    repeat (1000) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    hit = 1'b0;
    for (int i = 0; i < FRAME_CYC + 200 && !hit; i++) begin
      @(negedge clk);
      hit = bus.done;
    end
    chk("done_seen", 32'(hit), 32'd1);
    if (hit) begin
      chk("frame_cycles", 32'(cyc - t0), 32'(FRAME_CYC));
      chk("ce_n_at_done", 32'(bus.lcd_ce_n), 32'd1);
      chk("busy_at_done", 32'(bus.busy), 32'd1);
      chk("mosi_at_done", 32'(bus.lcd_mosi), 32'd0);
      @(negedge clk);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
    end
    repeat (50) @(negedge clk);
    chk("done_count", 32'(n_done - d0), 32'd1);
    chk("rst_low_frame", 32'(rst_lo - r0), 32'(RST_CYCLES));
    chk("bytes_rx", 32'(nbyte), 32'(TOTAL));
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    chk("half_period_err", 32'(hp_err), 32'd0);
    chk("dc_unstable_err", 32'(dc_err), 32'd0);
    chk("ce_n_high_err", 32'(ce_err), 32'd0);
    chk("addr_seq_err", 32'(addr_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pcd8544_refresh_ctrl.md
Name: pcd8544_refresh_ctrl

Overview:
Sequencer that drives a PCD8544 84x48 LCD from the static-screen frame RAM. On a start request it pulses the LCD reset line. It then reads CFG_BYTES command bytes followed by DATA_BYTES pixel bytes from RAM and serializes each one, MSB first, over a mode-0 SPI link. It generates the D/C line per byte, using the RAM address as the command/data boundary. It sits between the Wishbone-side screen RAM and the LCD pins.

Parameters:
ADDR_W, 13, width of the frame-RAM address bus
CFG_BYTES, 5, number of leading command bytes (sent with dc=0) at addresses 0..CFG_BYTES-1
DATA_BYTES, 504, number of pixel bytes following the commands (84*48/8)
CLK_DIV, 4, clk cycles per sck half-period; must be >= 1
RST_CYCLES, 16, clk cycles lcd_rst_n is held low; must be >= 1

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle refresh request; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle pulse when the last byte completes
mem_addr  out  ADDR_W  frame-RAM read address, registered
mem_data  in  8  frame-RAM read data, valid 1 clk after mem_addr
lcd_rst_n  out  1  LCD reset, active low
lcd_ce_n  out  1  LCD chip enable, active low
lcd_dc  out  1  0 = command byte, 1 = display data
lcd_sck  out  1  SPI clock, CPOL=0
lcd_mosi  out  1  SPI data, MSB first

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: busy=0, done=0, mem_addr=0, lcd_rst_n=1, lcd_ce_n=1, lcd_dc=0, lcd_sck=0, lcd_mosi=0. State is IDLE. Byte index, bit counter and divider are all 0.
- rst asserted mid-operation: outputs take their reset values at the next edge. There is no completion pulse and no partial byte is resumed.
- TOTAL = CFG_BYTES + DATA_BYTES. idx runs 0..TOTAL-1 and is ADDR_W wide.
- States and transitions:
  - IDLE: start=1 -> LCD_RST. start=0 -> stay.
  - LCD_RST: lcd_rst_n=0 for exactly RST_CYCLES cycles, then lcd_rst_n=1 -> FETCH, with idx=0.
  - FETCH: mem_addr<=idx. -> WAIT.
  - WAIT: one cycle for RAM latency. -> LOAD.
  - LOAD: shift register<=mem_data; lcd_mosi<=mem_data[7]; lcd_ce_n<=0; lcd_dc<=(idx<CFG_BYTES)?0:1; lcd_sck stays 0. -> SHIFT.
  - SHIFT: for each of 8 bits, sck is held low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - The rising edge occurs while mosi is stable.
    - On each falling edge the register shifts left and mosi takes the next bit.
    - After the 8th high phase, sck<=0. If idx==TOTAL-1 -> DONE, else idx<=idx+1 -> FETCH.
  - DONE: lcd_ce_n<=1, done=1 for this one cycle, dc and mosi<=0. -> IDLE.
- lcd_ce_n remains low across byte boundaries (FETCH/WAIT/LOAD gaps) once the first byte has loaded.
- lcd_dc changes only in LOAD, so it is stable for the entire byte, with setup >= CLK_DIV before the first sck rise.
- dc boundary is exact: idx=CFG_BYTES-1 is sent with dc=0, and idx=CFG_BYTES is sent with dc=1. CFG_BYTES=0 means every byte has dc=1.
- Per-byte duration: 3 + 16*CLK_DIV clk cycles.
- Frame duration from the accepted start to the done pulse: RST_CYCLES + TOTAL*(3+16*CLK_DIV) + 1.
- start while busy: ignored, not queued.
- busy=1 in every state except IDLE. busy falls in the cycle after DONE.

Optional Feature:
Macro PCD8544_CONT_REFRESH_EN.
- When defined, DONE goes to FETCH with idx=CFG_BYTES instead of IDLE, and lcd_ce_n is still pulsed high for that one DONE cycle.
- The result is continuous retransmission of data bytes only, with no LCD reset and no config bytes. busy stays 1 and done pulses once per frame. Only rst stops the loop.
- When undefined, behaviour is exactly single-shot as above.

Decomposition:
- Shared package pcd8544_pkg holds:
  - the state encoding (IDLE, LCD_RST, FETCH, WAIT, LOAD, SHIFT, DONE);
  - PCD8544 constants: LCD_COLS=84, LCD_ROWS=48, LCD_FRAME_BYTES=504, default CFG_BYTES=5.
- One natural sub-module, spi_byte_tx, holds the divider, 8-bit shift register and bit counter, with load/busy/last handshake. The sequencer FSM stays in pcd8544_refresh_ctrl.

Test Plan:
- Reset then idle: rst for 2 cycles, no start -> all outputs at reset values. lcd_ce_n=1, lcd_rst_n=1 held for 100 cycles.
- LCD reset pulse: start with RST_CYCLES=16 -> busy=1 next cycle. lcd_rst_n low for exactly 16 cycles, then first mem_addr=0.
- dc boundary: CFG_BYTES=5, RAM[0..5]=21,B1,04,14,20,AA -> SPI decode gives 5 bytes with dc=0, then 0xAA with dc=1. dc is constant within each byte.
- Serialization: CLK_DIV=2, RAM[0]=0xA5 -> mosi bits 1,0,1,0,0,1,0,1 sampled on sck rises. Each sck half-period is 2 clk. Byte takes 35 cycles.
- Full frame: CLK_DIV=1, default sizes -> 509 bytes received. done pulses once, exactly 16+509*19+1=9688 cycles after start. ce_n rises with done. Second start mid-frame is ignored.
- Reset mid-byte: assert rst during bit 3 of byte 7 -> next edge lcd_sck=0, lcd_ce_n=1, busy=0, no done. A new start replays from the reset pulse and address 0.
